// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU opcodes, forward selects
// and the ID/EX register bundle.
package mips_pkg;

    localparam logic [3:0] ALUC_ADDU = 4'b0000;
    localparam logic [3:0] ALUC_SUBU = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0011;
    localparam logic [3:0] ALUC_AND  = 4'b0100;
    localparam logic [3:0] ALUC_OR   = 4'b0101;
    localparam logic [3:0] ALUC_XOR  = 4'b0110;
    localparam logic [3:0] ALUC_NOR  = 4'b0111;
    localparam logic [3:0] ALUC_LUI  = 4'b1000;
    localparam logic [3:0] ALUC_SLTU = 4'b1010;
    localparam logic [3:0] ALUC_SLT  = 4'b1011;
    localparam logic [3:0] ALUC_SRA  = 4'b1100;
    localparam logic [3:0] ALUC_SRL  = 4'b1101;
    localparam logic [3:0] ALUC_SLL  = 4'b1110;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        use_imm;
        logic        use_shamt;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext_imm;
        logic [3:0]  aluc;
    } id_ex_t;

    function automatic logic [31:0] ext_imm16(
        input logic [15:0] imm,
        input logic        sext
    );
        return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM over MEM/WB over
// the latched register value; $0 is never forwarded.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [4:0]  ra_i,
    input  logic [31:0] val_i,
    input  logic        exmem_we_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [31:0] exmem_val_i,
    input  logic        memwb_we_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_val_i,
    output logic [31:0] val_o
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_REG;
        if (ra_i != REG_ZERO) begin
            if (exmem_we_i && exmem_rd_i == ra_i)
                sel = FWD_EXMEM;
            else if (memwb_we_i && memwb_rd_i == ra_i)
                sel = FWD_MEMWB;
        end
    end

    always_comb begin
        val_o = val_i;
        unique case (sel)
            FWD_EXMEM: val_o = exmem_val_i;
            FWD_MEMWB: val_o = memwb_val_i;
            default:   val_o = val_i;
        endcase
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX register with operand forwarding, ALU operand select
// and load-use hazard detection.
module ex_issue_stage
    import mips_pkg::*;
#(
    parameter bit RST_PC_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_use_imm,
    input  logic        id_sext,
    input  logic        id_use_shamt,
    input  logic        id_reads_rs,
    input  logic        id_reads_rt,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [4:0]  id_shamt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [3:0]  id_aluc,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic [4:0]  ex_rd_addr,
    output logic        load_use_stall
);

    id_ex_t ex_q, ex_d, id_pkt, rst_val;
    logic [31:0] fwd_rs, fwd_rt;

    fwd_mux u_fwd_rs (
        .ra_i        (ex_q.rs_addr),
        .val_i       (ex_q.rs),
        .exmem_we_i  (exmem_reg_write),
        .exmem_rd_i  (exmem_rd),
        .exmem_val_i (exmem_result),
        .memwb_we_i  (memwb_reg_write),
        .memwb_rd_i  (memwb_rd),
        .memwb_val_i (memwb_data),
        .val_o       (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .ra_i        (ex_q.rt_addr),
        .val_i       (ex_q.rt),
        .exmem_we_i  (exmem_reg_write),
        .exmem_rd_i  (exmem_rd),
        .exmem_val_i (exmem_result),
        .memwb_we_i  (memwb_reg_write),
        .memwb_rd_i  (memwb_rd),
        .memwb_val_i (memwb_data),
        .val_o       (fwd_rt)
    );

    always_comb begin
        id_pkt           = '0;
        id_pkt.valid     = 1'b1;
        id_pkt.reg_write = id_reg_write;
        id_pkt.mem_read  = id_mem_read;
        id_pkt.use_imm   = id_use_imm;
        id_pkt.use_shamt = id_use_shamt;
        id_pkt.rs_addr   = id_rs_addr;
        id_pkt.rt_addr   = id_rt_addr;
        id_pkt.rd_addr   = id_rd_addr;
        id_pkt.shamt     = id_shamt;
        id_pkt.rs        = id_rs_data;
        id_pkt.rt        = id_rt_data;
        id_pkt.ext_imm   = ext_imm16(id_imm, id_sext);
        id_pkt.aluc      = id_aluc;
        if (!id_valid)
            id_pkt = '0;
    end

    assign load_use_stall = ex_q.valid && ex_q.mem_read
        && (ex_q.rd_addr != REG_ZERO) && id_valid
        && ((id_reads_rs && id_rs_addr == ex_q.rd_addr)
         || (id_reads_rt && id_rt_addr == ex_q.rd_addr));

    // During a stall the operands re-latch their forwarded values so
    // results retiring from MEM/WB in the meantime are not lost.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d.rs = fwd_rs;
            ex_d.rt = fwd_rt;
        end else if (load_use_stall) begin
            ex_d = '0;
        end else begin
            ex_d = id_pkt;
        end
    end

    always_comb begin
        rst_val           = ex_q;
        rst_val.valid     = 1'b0;
        rst_val.reg_write = 1'b0;
        rst_val.mem_read  = 1'b0;
        if (RST_PC_NOP)
            rst_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= rst_val;
        else
            ex_q <= ex_d;
    end

    assign alu_a         = ex_q.use_shamt ? {27'b0, ex_q.shamt} : fwd_rs;
    assign alu_b         = ex_q.use_imm ? ex_q.ext_imm : fwd_rt;
    assign alu_aluc      = ex_q.aluc;
    assign ex_store_data = fwd_rt;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_rd_addr    = ex_q.rd_addr;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: expected EX outputs are
// queued with each ID stimulus and popped after the capturing edge.
module tb_ex_issue_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid, id_reg_write, id_mem_read, id_use_imm;
    logic        id_sext, id_use_shamt, id_reads_rs, id_reads_rt;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [3:0]  id_aluc;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_aluc;
    logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
    logic [4:0]  ex_rd_addr;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic [31:0] sd;
        logic        valid;
        logic        rw;
        logic        mr;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    ex_issue_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_use_imm      (id_use_imm),
        .id_sext         (id_sext),
        .id_use_shamt    (id_use_shamt),
        .id_reads_rs     (id_reads_rs),
        .id_reads_rt     (id_reads_rt),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .id_shamt        (id_shamt),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_aluc         (id_aluc),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_aluc        (alu_aluc),
        .ex_store_data   (ex_store_data),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_rd_addr      (ex_rd_addr),
        .load_use_stall  (load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] aluc, input logic [31:0] sd,
                        input logic v, input logic rw, input logic mr,
                        input logic [4:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.aluc = aluc; e.sd = sd;
        e.valid = v; e.rw = rw; e.mr = mr; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        push(32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic step_cmp(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_a"},  alu_a, e.a);
            chk({tag, "_b"},  alu_b, e.b);
            chk({tag, "_op"}, 32'(alu_aluc), 32'(e.aluc));
            chk({tag, "_sd"}, ex_store_data, e.sd);
            chk({tag, "_v"},  32'(ex_valid), 32'(e.valid));
            chk({tag, "_rw"}, 32'(ex_reg_write), 32'(e.rw));
            chk({tag, "_mr"}, 32'(ex_mem_read), 32'(e.mr));
            chk({tag, "_rd"}, 32'(ex_rd_addr), 32'(e.rd));
        end
    endtask

    task automatic id_idle();
        id_valid = 0; id_reg_write = 0; id_mem_read = 0;
        id_use_imm = 0; id_sext = 0; id_use_shamt = 0;
        id_reads_rs = 0; id_reads_rt = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_shamt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_aluc = 0;
    endtask

    task automatic fwd_idle();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    initial begin
        logic [4:0]  ra, er, mr;
        logic        ew, mw;
        logic [31:0] rv, ev, mv, ea;

        rst = 1; stall = 0; flush = 0;
        id_idle();
        fwd_idle();

        // reset with a live instruction on the ID side
        id_valid = 1; id_reg_write = 1; id_rs_addr = 8;
        id_rs_data = 32'h55; id_rd_addr = 9; id_aluc = ALUC_ADD;
        push_bubble();
        step_cmp("reset");
        chk("reset_lus", 32'(load_use_stall), 32'd0);
        rst = 0;

        // addi sign-extended
        id_idle();
        id_valid = 1; id_reg_write = 1; id_use_imm = 1; id_sext = 1;
        id_rs_addr = 8; id_rs_data = 5; id_rt_addr = 9;
        id_rt_data = 32'h11; id_rd_addr = 9; id_imm = 16'hFFFF;
        id_aluc = ALUC_ADD;
        push(5, 32'hFFFF_FFFF, ALUC_ADD, 32'h11, 1, 1, 0, 9);
        step_cmp("addi");
        chk("addi_lus", 32'(load_use_stall), 32'd0);

        // zero-extended immediate
        id_sext = 0;
        push(5, 32'h0000_FFFF, ALUC_ADD, 32'h11, 1, 1, 0, 9);
        step_cmp("zext");

        // both forward sources match rs: EX/MEM wins
        id_idle();
        id_valid = 1; id_reg_write = 1; id_rs_addr = 3; id_rs_data = 1;
        id_rt_addr = 5; id_rt_data = 2; id_rd_addr = 10;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 7;
        memwb_reg_write = 1; memwb_rd = 3; memwb_data = 9;
        push(7, 2, ALUC_ADDU, 2, 1, 1, 0, 10);
        step_cmp("fwd_both");
        exmem_reg_write = 0;
        #1 chk("fwd_memwb_a", alu_a, 32'd9);
        memwb_reg_write = 0;
        #1 chk("fwd_none_a", alu_a, 32'd1);

        // $0 is never forwarded
        id_rs_addr = 0; id_rs_data = 0;
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 9;
        memwb_reg_write = 1; memwb_rd = 0; memwb_data = 9;
        push(0, 2, ALUC_ADDU, 2, 1, 1, 0, 10);
        step_cmp("fwd_zero");
        fwd_idle();

        // lw $4 followed by a reader of $4
        id_idle();
        id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_use_imm = 1;
        id_sext = 1; id_rs_addr = 1; id_rs_data = 100; id_rt_addr = 4;
        id_rd_addr = 4; id_imm = 16'd8;
        push(100, 8, ALUC_ADDU, 0, 1, 1, 1, 4);
        step_cmp("lw");
        id_idle();
        id_valid = 1; id_reg_write = 1; id_reads_rs = 1; id_reads_rt = 1;
        id_rs_addr = 2; id_rt_addr = 4; id_rd_addr = 5;
        #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
        push_bubble();
        step_cmp("lu_bubble");
        chk("lu_clear", 32'(load_use_stall), 32'd0);

        // stall keeps a MEM/WB result that retires mid-stall
        id_idle();
        id_valid = 1; id_reg_write = 1; id_rs_addr = 1; id_rs_data = 3;
        id_rt_addr = 6; id_rt_data = 32'h1111; id_rd_addr = 7;
        id_aluc = ALUC_SUBU;
        push(3, 32'h1111, ALUC_SUBU, 32'h1111, 1, 1, 0, 7);
        step_cmp("pre_stall");
        stall = 1;
        id_rs_data = 99; id_rd_addr = 12;
        memwb_reg_write = 1; memwb_rd = 6; memwb_data = 32'hABCD;
        push(3, 32'hABCD, ALUC_SUBU, 32'hABCD, 1, 1, 0, 7);
        step_cmp("stall1");
        push(3, 32'hABCD, ALUC_SUBU, 32'hABCD, 1, 1, 0, 7);
        step_cmp("stall2");
        memwb_reg_write = 0; stall = 0;
        #1 chk("stall_sd", ex_store_data, 32'hABCD);
        chk("stall_rd", 32'(ex_rd_addr), 32'd7);
        fwd_idle();

        // sll with maximal shamt
        id_idle();
        id_valid = 1; id_reg_write = 1; id_use_shamt = 1; id_shamt = 31;
        id_rt_addr = 2; id_rt_data = 1; id_rd_addr = 8;
        id_aluc = ALUC_SLL;
        push(31, 1, ALUC_SLL, 1, 1, 1, 0, 8);
        step_cmp("sll");

        // flush beats stall
        stall = 1; flush = 1;
        push_bubble();
        step_cmp("flush_stall");
        stall = 0; flush = 0;

        // reset beats stall
        push(31, 1, ALUC_SLL, 1, 1, 1, 0, 8);
        step_cmp("reload");
        stall = 1; rst = 1;
        push_bubble();
        step_cmp("rst_stall");
        stall = 0; rst = 0;

        // randomized forwarding on rs against a priority model
        for (int i = 0; i < 8; i++) begin
            ra = 5'($urandom_range(0, 3));
            er = 5'($urandom_range(0, 3));
            mr = 5'($urandom_range(0, 3));
            ew = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            rv = $urandom; ev = $urandom; mv = $urandom;
            id_idle();
            id_valid = 1; id_rs_addr = ra; id_rs_data = rv;
            id_rt_addr = 0; id_rt_data = 0;
            exmem_reg_write = ew; exmem_rd = er; exmem_result = ev;
            memwb_reg_write = mw; memwb_rd = mr; memwb_data = mv;
            if (ra != 0 && ew && er == ra)
                ea = ev;
            else if (ra != 0 && mw && mr == ra)
                ea = mv;
            else
                ea = rv;
            push(ea, 0, ALUC_ADDU, 0, 1, 0, 0, 0);
            step_cmp($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline register and operand-select stage sitting directly upstream of the `alu` block. It latches decoded instructions from ID and forwards results from EX/MEM and MEM/WB. It builds the ALU operands `a`, `b` and `aluc`, and detects load-use hazards. Its outputs drive the ALU inputs combinationally within the EX cycle.

## Interface
- `RST_PC_NOP` = 1: on reset, the register holds a bubble (all-zero fields, `ex_valid`=0).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold the ID/EX register (external, e.g. mul/div busy).
- `flush` in 1: load a bubble next edge (branch/exception).
- `id_valid`, `id_reg_write`, `id_mem_read`, `id_use_imm`, `id_sext`, `id_use_shamt`, `id_reads_rs`, `id_reads_rt` in 1 each: decoded controls.
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr`, `id_shamt` in 5 each: register addresses and shift amount.
- `id_rs_data`, `id_rt_data` in 32 each: register file read data.
- `id_imm` in 16: instruction immediate.
- `id_aluc` in 4: ALU opcode, using the ALU's encoding.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forward source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_data` in 32: MEM/WB forward source.
- `alu_a`, `alu_b` out 32, `alu_aluc` out 4: ALU operands.
- `ex_store_data` out 32: forwarded rt value for stores.
- `ex_valid`, `ex_reg_write`, `ex_mem_read` out 1; `ex_rd_addr` out 5: passed down the pipe.
- `load_use_stall` out 1: tells ID/IF to hold.

## Operation
- Register update priority per edge: `rst` > `flush` > `stall` > `load_use_stall` > normal load.
  - `rst` / `flush`: bubble, with every field 0 (`ex_valid`, `ex_reg_write`, `ex_mem_read` = 0).
  - `stall`: hold all fields except `rs_q`/`rt_q`, which reload with their current forwarded values. This keeps MEM/WB results that retire during the stall.
  - `load_use_stall` (no `stall`): insert bubble.
  - Normal: capture all `id_*` fields. `id_valid`=0 captures a bubble.
- Forwarding is combinational on the latched `rs_q`/`rt_q`, per operand, for address `ra`:
  - Use `exmem_result` if `exmem_reg_write` && `exmem_rd`==`ra` && `ra`!=0.
  - Else use `memwb_data` if `memwb_reg_write` && `memwb_rd`==`ra` && `ra`!=0.
  - Else use the latched register value.
  - `$0` is never forwarded.
- Operand select:
  - `alu_a` = `{27'b0, shamt_q}` if `use_shamt_q`, else `fwd_rs`.
  - `alu_b` = `ext_imm_q` if `use_imm_q`, else `fwd_rt`.
  - `ext_imm` is sign-extended if `id_sext`, else zero-extended. Extension is computed in ID-side logic before latching.
  - `ex_store_data` = `fwd_rt` always.
  - `alu_aluc` = `aluc_q`.
- Load-use: `load_use_stall` = `ex_valid` & `ex_mem_read` & `ex_rd_addr`!=0 & `id_valid` & ((`id_reads_rs` & `id_rs_addr`==`ex_rd_addr`) | (`id_reads_rt` & `id_rt_addr`==`ex_rd_addr`)). This signal is purely combinational.

## Timing
- Latency: ID fields appear on the outputs 1 cycle after the capturing edge. Forwarding adds no cycle.
- Reset values: `alu_a`=`alu_b`=`ex_store_data`=0, `alu_aluc`=0 (Addu), `ex_valid`=`ex_reg_write`=`ex_mem_read`=0, `ex_rd_addr`=0, `load_use_stall`=0.
- Reset mid-stall: bubble next edge; stall is ignored.
- `flush` and `stall` together: `flush` wins.
- `load_use_stall` while `stall`: the hold wins; the bubble is inserted on the first non-stall edge only if the hazard persists.
- EX/MEM and MEM/WB both matching: EX/MEM wins, as the younger result.

## Structure
- The shared package `mips_pkg` holds:
  - `ALUC_*` constants matching the ALU encoding (ADDU=0000, SUBU=0001, … SRL=1101).
  - `fwd_sel_t` enum {`FWD_REG`, `FWD_EXMEM`, `FWD_MEMWB`}.
  - `REG_ZERO`=5'd0.
- One sub-module, `fwd_mux`: takes `ra` + value + both forward sources and returns the selected value. It is instantiated twice (rs, rt).

## Test plan
- Reset with `id_valid`=1 -> after the edge, all outputs are 0 and `ex_valid`=0.
- `addi` rs=$8 (data 5), imm=16'hFFFF, `id_sext`=1, `aluc`=0010 -> next cycle `alu_a`=5, `alu_b`=32'hFFFF_FFFF, `alu_aluc`=0010.
- Latched rs=$3 with `exmem_rd`=3 (result 7) and `memwb_rd`=3 (data 9), both `reg_write` -> `alu_a`=7. With rs=$0 and both forward sources targeting $0 at value 9 -> `alu_a` = latched 0.
- EX holds `lw` to $4 while ID reads rt=$4 -> `load_use_stall`=1; next edge `ex_valid`=0.
- `stall` held 2 cycles while `memwb_rd`=rt=$6 with data 32'hABCD then retires -> after release, `ex_store_data`=32'hABCD.
- `sll` with shamt=31, rt=1 -> `alu_a`=31, `alu_b`=1. `flush`+`stall` together -> bubble.
